// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// FSM state encoding, byte-enable width and an access-size decoder.
package lsu_pkg;

  localparam int BE_W = 32 / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Stores only know SB/SH and treat every other code as SW; loads decode
  // the size from funct3[1:0] so LBU/LHU share the LB/LH sizes.
  function automatic size_e access_size(input logic is_store, input logic [2:0] f3);
    size_e sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3[1:0])
        2'b00:   sz = SZ_B;
        2'b01:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension. Purely
// combinational; the store side and load side have independent inputs.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_a,
  input  logic [XLEN-1:0] st_data,
  output logic [BE_W-1:0] st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_a,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enable the addressed lanes and replicate data into all lanes.
  always_comb begin
    st_be    = '1;
    st_wdata = st_data;
    case (access_size(1'b1, st_funct3))
      SZ_B: begin
        st_be    = 4'b0001 << st_a;
        st_wdata = {(XLEN/8){st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(XLEN/16){st_data[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then extend; funct3[2] means unsigned.
  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_a)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_a[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_rdata;
    case (access_size(1'b0, ld_funct3))
      SZ_B:    ld_data = ld_funct3[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                      : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = ld_funct3[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                      : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts an EX-stage memory op, runs a
// req/gnt/rvalid handshake to data memory and stalls the core meanwhile.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses skip the bus and complete at once with misalign=1. Without it,
// misaligned addresses are aligned down and misalign stays 0.
//
// Handshake: dmem_req is held with stable addr/we/be/wdata until the cycle
// dmem_gnt=1 (that edge accepts the request); for loads, dmem_rvalid is only
// sampled in WAIT, which starts the cycle after the grant. gnt outside REQ and
// rvalid outside WAIT are ignored.
module lsu #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_op_valid,
  input  logic            MemRW,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] Reg_rs2,
  output logic            lsu_busy,
  output logic            lsu_done,
  output logic [XLEN-1:0] load_data,
  output logic            misalign,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  import lsu_pkg::*;

  state_e          state_q, state_d;
  logic            lsu_done_q, lsu_done_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            misalign_q, misalign_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [BE_W-1:0] dmem_be_q, dmem_be_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      a_q, a_d;
  logic            store_q, store_d;

  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic            trap;

  // Store lanes come from the live EX inputs (captured on accept); load
  // extraction uses the latched offset/width against the returned data.
  lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (funct3),
    .st_a      (alu[1:0]),
    .st_data   (Reg_rs2),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_a      (a_q),
    .ld_rdata  (dmem_rdata),
    .ld_data   (ld_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  size_e op_size;
  // Flag halfwords on odd addresses and words not on a 4-byte boundary.
  always_comb begin
    op_size = access_size(MemRW, funct3);
    trap    = ((op_size == SZ_H) && alu[0]) ||
              ((op_size == SZ_W) && (alu[1:0] != 2'b00));
  end
`else
  assign trap = 1'b0;
`endif

  // Next-state, stall and registered-output updates for the access FSM.
  always_comb begin
    state_d      = state_q;
    lsu_done_d   = 1'b0;
    load_data_d  = load_data_q;
    misalign_d   = misalign_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    funct3_d     = funct3_q;
    a_d          = a_q;
    store_d      = store_q;
    lsu_busy     = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_busy = mem_op_valid;
        if (mem_op_valid) begin
          funct3_d = funct3;
          a_d      = alu[1:0];
          store_d  = MemRW;
          if (trap) begin
            state_d    = DONE;
            lsu_done_d = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = MemRW;
            dmem_addr_d  = {alu[XLEN-1:2], 2'b00};
            dmem_be_d    = st_be;
            dmem_wdata_d = st_wdata;
          end
        end
      end
      REQ: begin
        lsu_busy = 1'b1;
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (store_q) begin
            state_d    = DONE;
            lsu_done_d = 1'b1;
            misalign_d = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        lsu_busy = 1'b1;
        if (dmem_rvalid) begin
          state_d     = DONE;
          lsu_done_d  = 1'b1;
          misalign_d  = 1'b0;
          load_data_d = ld_data;
        end
      end
      default: begin
        // DONE: core advances on this edge; a pending mem_op_valid is not
        // accepted until the FSM is back in IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lsu_done_q   <= 1'b0;
      load_data_q  <= '0;
      misalign_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      funct3_q     <= '0;
      a_q          <= '0;
      store_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsu_done_q   <= lsu_done_d;
      load_data_q  <= load_data_d;
      misalign_q   <= misalign_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      funct3_q     <= funct3_d;
      a_q          <= a_d;
      store_q      <= store_d;
    end
  end

  assign lsu_done   = lsu_done_q;
  assign load_data  = load_data_q;
  assign misalign   = misalign_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a cycle-stepped driver sets the expected bus and
// stall behaviour from the access rules, a negedge monitor compares every
// cycle, and literal checks pin the model on the listed example accesses.
module tb_lsu;
  import lsu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_op_valid;
  logic            MemRW;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu;
  logic [XLEN-1:0] Reg_rs2;
  logic            lsu_busy;
  logic            lsu_done;
  logic [XLEN-1:0] load_data;
  logic            misalign;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_op_valid (mem_op_valid),
    .MemRW        (MemRW),
    .funct3       (funct3),
    .alu          (alu),
    .Reg_rs2      (Reg_rs2),
    .lsu_busy     (lsu_busy),
    .lsu_done     (lsu_done),
    .load_data    (load_data),
    .misalign     (misalign),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic            chk_en = 1'b0;
  logic            exp_busy, exp_done, exp_req, exp_we, exp_misalign;
  logic [XLEN-1:0] exp_addr, exp_wdata, exp_load_data;
  logic [3:0]      exp_be;
  logic [XLEN-1:0] exp_q[$];

  logic [XLEN-1:0] last_addr  = '0;
  logic [XLEN-1:0] last_wdata = '0;
  logic [3:0]      last_be    = '0;
  int              req_run      = 0;
  int              last_req_len = 0;
  int              req_total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = m_size(1'b1, f3);
    int unsigned v;
    if (sz == 1)      v = 1 << (addr % 4);
    else if (sz == 2) v = ((addr % 4) >= 2) ? 12 : 3;
    else              v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int unsigned sz = m_size(1'b1, f3);
    if (sz == 1) return {24'd0, rs2[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int unsigned   sz = m_size(1'b0, f3);
    int unsigned   off;
    longint unsigned v;
    off = (sz == 1) ? addr % 4 : (sz == 2) ? ((addr % 4) / 2) * 2 : 0;
    v = 64'(rdata >> (8 * off));
    if (sz < 4) begin
      v = v % (64'd1 << (8 * sz));
      if (f3[2] == 1'b0 && v >= (64'd1 << (8 * sz - 1)))
        v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
    end
    return v[31:0];
  endfunction

  function automatic logic m_trap(input logic st, input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int unsigned sz = m_size(st, f3);
    return (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, lsu_busy}, {31'd0, exp_busy});
      check("done", {31'd0, lsu_done}, {31'd0, exp_done});
      check("req", {31'd0, dmem_req}, {31'd0, exp_req});
      check("load_hold", load_data, exp_load_data);
      if (exp_req) begin
        check("addr", dmem_addr, exp_addr);
        check("be", {28'd0, dmem_be}, {28'd0, exp_be});
        check("wdata", dmem_wdata, exp_wdata);
        check("we", {31'd0, dmem_we}, {31'd0, exp_we});
      end
      if (exp_done) begin
        if (exp_q.size() == 0) check("done_queue", 32'd1, 32'd0);
        else check("done_data", load_data, exp_q.pop_front());
`ifdef LSU_MISALIGN_TRAP_EN
        check("misalign", {31'd0, misalign}, {31'd0, exp_misalign});
`endif
      end
`ifndef LSU_MISALIGN_TRAP_EN
      check("misalign_tied", {31'd0, misalign}, 32'd0);
`endif
    end
    if (dmem_req === 1'b1) begin
      last_addr  <= dmem_addr;
      last_wdata <= dmem_wdata;
      last_be    <= dmem_be;
      req_run    <= req_run + 1;
      req_total  <= req_total + 1;
    end else begin
      if (req_run != 0) last_req_len <= req_run;
      req_run <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: accept cycle, REQ (gnt after gdly cycles), WAIT (rvalid after
  // rdly cycles) for loads, then DONE. Spurious rvalid in REQ and gnt in WAIT.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input int gdly, input int rdly,
                        input logic [31:0] rdata);
    mem_op_valid = 1'b1;
    MemRW        = st;
    funct3       = f3;
    alu          = addr;
    Reg_rs2      = rs2;
    exp_busy     = 1'b1;
    exp_done     = 1'b0;
    exp_req      = 1'b0;
    step();
    if (m_trap(st, f3, addr)) begin
      exp_done     = 1'b1;
      exp_busy     = 1'b0;
      exp_misalign = 1'b1;
      exp_q.push_back(exp_load_data);
      step();
    end else begin
      exp_req   = 1'b1;
      exp_we    = st;
      exp_addr  = {addr[31:2], 2'b00};
      exp_be    = m_be(f3, addr);
      exp_wdata = m_wdata(f3, rs2);
      for (int i = 0; i < gdly; i++) begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A_5A5A;
        step();
      end
      dmem_rvalid = 1'b0;
      dmem_gnt    = 1'b1;
      step();
      dmem_gnt = 1'b0;
      exp_req  = 1'b0;
      if (!st) begin
        for (int i = 0; i < rdly; i++) begin
          dmem_gnt = 1'b1;
          step();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid   = 1'b0;
        exp_load_data = m_load(f3, addr, rdata);
      end
      exp_done     = 1'b1;
      exp_busy     = 1'b0;
      exp_misalign = 1'b0;
      exp_q.push_back(exp_load_data);
      step();
    end
    exp_done     = 1'b0;
    mem_op_valid = 1'b0;
    exp_busy     = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int req_before;

  initial begin
    rst          = 1'b1;
    mem_op_valid = 1'b0;
    MemRW        = 1'b0;
    funct3       = 3'd0;
    alu          = '0;
    Reg_rs2      = '0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_misalign = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    exp_load_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_be", {28'd0, dmem_be}, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_we", {31'd0, dmem_we}, 32'h0);
    check("rst_misalign", {31'd0, misalign}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // SW, immediate grant
    run_op(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    check("sw_addr", last_addr, 32'h100);
    check("sw_be", {28'd0, last_be}, 32'hF);
    check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    check("sw_req_len", last_req_len, 1);

    // SB top lane
    run_op(1'b1, F3_B, 32'h103, 32'h0000_00A5, 1, 0, 0);
    check("sb_be", {28'd0, last_be}, 32'h8);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    // LB / LBU on lane 1
    run_op(1'b0, F3_B, 32'h201, 0, 0, 0, 32'h1234_8056);
    check("lb_data", load_data, 32'hFFFF_FF80);
    run_op(1'b0, F3_BU, 32'h201, 0, 0, 0, 32'h1234_8056);
    check("lbu_data", load_data, 32'h0000_0080);

    // LH upper half, grant delayed 3 cycles
    run_op(1'b0, F3_H, 32'h302, 0, 3, 1, 32'h9ABC_0000);
    check("lh_req_len", last_req_len, 4);
    check("lh_addr", last_addr, 32'h300);
    check("lh_data", load_data, 32'hFFFF_9ABC);

    // SH upper half: load_data must not change on a store
    run_op(1'b1, F3_H, 32'h306, 32'h1234_BEEF, 0, 0, 0);
    check("sh_be", {28'd0, last_be}, 32'hC);
    check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh_keeps_load", load_data, 32'hFFFF_9ABC);

    // LHU lower half, funct3=111 full word, store funct3=100 as word
    run_op(1'b0, F3_HU, 32'h500, 0, 0, 2, 32'h0000_F00D);
    check("lhu_data", load_data, 32'h0000_F00D);
    run_op(1'b0, 3'b111, 32'h504, 0, 2, 0, 32'hCAFE_0001);
    check("l111_data", load_data, 32'hCAFE_0001);
    run_op(1'b1, 3'b100, 32'h508, 32'h0BAD_F00D, 0, 0, 0);
    check("s100_be", {28'd0, last_be}, 32'hF);

    // Misaligned word load
    req_before = req_total;
    run_op(1'b0, F3_W, 32'h402, 0, 0, 0, 32'h7654_3210);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_no_req", req_total - req_before, 0);
    check("mis_flag", {31'd0, misalign}, 32'h1);
    check("mis_keeps_load", load_data, 32'hCAFE_0001);
    run_op(1'b0, F3_W, 32'h404, 0, 0, 0, 32'h1111_2222);
    check("mis_cleared", {31'd0, misalign}, 32'h0);
`else
    check("mis_addr", last_addr, 32'h400);
    check("mis_flag", {31'd0, misalign}, 32'h0);
    check("mis_data", load_data, 32'h7654_3210);
`endif

    // Reset while in WAIT, late rvalid must be ignored
    mem_op_valid = 1'b1; MemRW = 1'b0; funct3 = F3_W; alu = 32'h400; Reg_rs2 = '0;
    exp_busy = 1'b1;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF; exp_wdata = 32'h0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; exp_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; mem_op_valid = 1'b0; exp_busy = 1'b0;
    exp_load_data = '0; exp_misalign = 1'b0;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    step();
    check("rst_mid_addr", dmem_addr, 32'h0);
    check("rst_mid_be", {28'd0, dmem_be}, 32'h0);
    check("rst_mid_wdata", dmem_wdata, 32'h0);
    check("rst_mid_load", load_data, 32'h0);
    check("rst_mid_busy", {31'd0, lsu_busy}, 32'h0);

    // Normal op after the aborted one
    run_op(1'b0, F3_B, 32'h603, 0, 1, 1, 32'h7F00_0000);
    check("post_rst_lb", load_data, 32'h0000_007F);

    step();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and rs2 as store data, then runs a req/gnt/rvalid handshake to data memory.
- Generates byte enables and lane-replicated store data; extracts and sign- or zero-extends load data.
- Stalls the core via lsu_busy until the access completes.

Parameters:
- XLEN, 32, datapath and address width.
- BE_W, XLEN/8, number of byte enables.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- mem_op_valid  in  1  EX result is a load/store; held stable while lsu_busy=1.
- MemRW  in  1  1=store, 0=load.
- funct3  in  3  RV32I width/sign field.
- alu  in  XLEN  effective address (ALU output).
- Reg_rs2  in  XLEN  store data.
- lsu_busy  out  1  stall request to the core.
- lsu_done  out  1  one-cycle completion pulse.
- load_data  out  XLEN  extended load result, valid when lsu_done=1.
- misalign  out  1  misaligned-access flag, valid with lsu_done.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  BE_W  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.

Behaviour:
- Reset: state IDLE. All registered outputs are 0: lsu_done, load_data, misalign, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be. Reset mid-operation aborts the access at that edge; any later gnt/rvalid is ignored.
- lsu_busy is combinational:
  - in IDLE, lsu_busy = mem_op_valid;
  - in REQ and WAIT, lsu_busy = 1;
  - in DONE, lsu_busy = 0, so the core advances on the DONE edge.
- IDLE: when mem_op_valid=1, latch alu, Reg_rs2, funct3 and MemRW, then go to REQ.
- REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt=1.
  - On gnt with a store, go to DONE.
  - On gnt with a load, go to WAIT.
- WAIT: dmem_req=0. On dmem_rvalid=1, register the extended load data and go to DONE.
- DONE: lsu_done=1 for exactly one cycle, then IDLE. mem_op_valid is ignored in DONE.
- Minimum latency, counted from the accept edge with gnt in the first REQ cycle:
  - store: lsu_done in the 2nd cycle after accept;
  - load: lsu_done in the 3rd cycle after accept (rvalid arrives no earlier than the cycle after gnt).
- gnt outside REQ and rvalid outside WAIT are ignored.
- Store lanes, with a = addr[1:0]:
  - SB (000): be = 4'b0001<<a; wdata = {4{rs2[7:0]}}.
  - SH (001): be = a[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW (010 or any other): be = 1111; wdata = rs2.
- Load extraction:
  - LB (000) / LBU (100): byte at lane a, sign- or zero-extended.
  - LH (001) / LHU (101): half selected by a[1], sign- or zero-extended.
  - LW (010), and 011/110/111: full word.
- load_data holds its value until the next load's DONE; stores do not update it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with a[0]=1, or a word with a!=0, issues no request. The FSM goes IDLE->DONE directly, with misalign=1 and load_data unchanged.
  - misalign clears on the next DONE.
- Undefined:
  - Misaligned addresses are silently aligned down: a halfword uses a[1] only, a word ignores a.
  - misalign is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {IDLE, REQ, WAIT, DONE};
  - localparam BE_W.
- Sub-module lsu_align: combinational store-lane generation (be, wdata) and load extraction/extension. It is shared by the FSM and unit-testable alone.

Test Plan:
- SW addr=0x100, rs2=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, lsu_done 2 cycles after accept, lsu_busy=0 in DONE.
- SB addr=0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
- LB addr=0x201, rdata=0x12348056, rvalid 1 cycle after gnt -> load_data=0xFFFFFF80; the same access as LBU -> 0x00000080.
- LH addr=0x302, gnt delayed 3 cycles, rdata=0x9ABC0000 -> dmem_req held 4 cycles with stable addr, load_data=0xFFFF9ABC.
- LW addr=0x400, rst asserted while in WAIT, rvalid 2 cycles later -> returns to IDLE, no lsu_done, outputs 0.
- LW addr=0x402 -> with LSU_MISALIGN_TRAP_EN: no dmem_req, lsu_done and misalign=1 one cycle after accept. Without the macro: dmem_addr=0x400, normal completion, misalign=0.
